// File: rtl/pulse_shrink.sv
// Pulse qualifier: measures the high time of a stretched pulse on i_Din and
// turns an in-range pulse back into a one-cycle strobe, flagging short/long ones.
module pulse_shrink #(
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 40,
    parameter int CNT_W   = 8,
    parameter int GAP_LEN = 2,
    parameter int SYNC_EN = 1
) (
    input  logic             i_Sys_clk,
    input  logic             i_Rst_n,
    input  logic             i_Din,
    output logic             o_Pulse,
    output logic [CNT_W-1:0] o_Width,
    output logic             o_Width_vld,
    output logic             o_Err_short,
    output logic             o_Err_long,
    output logic             o_Busy
);

    localparam int GAP_W = $clog2(GAP_LEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEAS = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_C   = GAP_W'(GAP_LEN);
    localparam logic [1:0]       S_AFTER = (GAP_LEN == 1) ? S_IDLE : S_GAP;

    if (MIN_LEN < 1 || MAX_LEN < MIN_LEN || CNT_W < 2 || CNT_W > 30 ||
        MAX_LEN > (1 << CNT_W) - 2 || GAP_LEN < 1 ||
        (SYNC_EN != 0 && SYNC_EN != 1)) begin : g_bad_param
        $error("pulse_shrink: illegal parameter combination");
    end

    logic din_s;

    // Synchronizer resets high so a line already high at reset is ignored
    if (SYNC_EN != 0) begin : g_sync
        logic [1:0] sync_q;
        always_ff @(posedge i_Sys_clk) begin
            if (!i_Rst_n) begin
                sync_q <= 2'b11;
            end else begin
                sync_q <= {sync_q[0], i_Din};
            end
        end
        assign din_s = sync_q[1];
    end else begin : g_nosync
        assign din_s = i_Din;
    end

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_n;
    logic [CNT_W-1:0] width_n;
    logic             pulse_n;
    logic             short_n;
    logic             long_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gap_n   = gap_cnt;
        width_n = o_Width;
        pulse_n = 1'b0;
        short_n = 1'b0;
        long_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (din_s) begin
                    state_n = S_MEAS;
                    cnt_n   = CNT_W'(1);
                end
            end
            S_MEAS: begin
                if (din_s) begin
                    if (cnt < MAX_C) begin
                        cnt_n = cnt + 1'b1;
                    end else begin
                        state_n = S_OVER;
                        long_n  = 1'b1;
                    end
                end else begin
                    if (cnt >= MIN_C) begin
                        pulse_n = 1'b1;
                        width_n = cnt;
                    end else begin
                        short_n = 1'b1;
                    end
                    state_n = S_AFTER;
                    gap_n   = GAP_W'(1);
                end
            end
            S_OVER: begin
                if (!din_s) begin
                    state_n = S_AFTER;
                    gap_n   = GAP_W'(1);
                end
            end
            S_GAP: begin
                // Any high inside the gap is a glitch: restart the low run
                if (din_s) begin
                    gap_n = '0;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                    if (gap_n == GAP_C) begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_GAP;
        endcase
    end

    always_ff @(posedge i_Sys_clk) begin
        if (!i_Rst_n) begin
            state       <= S_GAP;
            cnt         <= '0;
            gap_cnt     <= '0;
            o_Width     <= '0;
            o_Pulse     <= 1'b0;
            o_Width_vld <= 1'b0;
            o_Err_short <= 1'b0;
            o_Err_long  <= 1'b0;
            o_Busy      <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            gap_cnt     <= gap_n;
            o_Width     <= width_n;
            o_Pulse     <= pulse_n;
            o_Width_vld <= pulse_n;
            o_Err_short <= short_n;
            o_Err_long  <= long_n;
            o_Busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_shrink.sv
// Directed bench for pulse_shrink: a synchronized instance plus an
// unsynchronized one for the direct-input latency case.
module tb_pulse_shrink;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din0;

    logic       pulse, vld, es, el, busy;
    logic [7:0] width;
    logic       pulse0, vld0, es0, el0, busy0;
    logic [7:0] width0;

    int cyc;
    int vectors = 0;
    int miss = 0;
    int n_p, n_s, n_l, last_p, last_l;
    int n0_p, n0_s, n0_l, last0_p;
    int r, f;

    always #5 clk = ~clk;

    pulse_shrink dut (
        .i_Sys_clk  (clk),
        .i_Rst_n    (rst_n),
        .i_Din      (din),
        .o_Pulse    (pulse),
        .o_Width    (width),
        .o_Width_vld(vld),
        .o_Err_short(es),
        .o_Err_long (el),
        .o_Busy     (busy)
    );

    pulse_shrink #(.SYNC_EN(0)) dut0 (
        .i_Sys_clk  (clk),
        .i_Rst_n    (rst_n),
        .i_Din      (din0),
        .o_Pulse    (pulse0),
        .o_Width    (width0),
        .o_Width_vld(vld0),
        .o_Err_short(es0),
        .o_Err_long (el0),
        .o_Busy     (busy0)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear();
        n_p = 0; n_s = 0; n_l = 0; last_p = -1; last_l = -1;
        n0_p = 0; n0_s = 0; n0_l = 0; last0_p = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pulse) begin n_p++; last_p = cyc; end
        if (es) n_s++;
        if (el) begin n_l++; last_l = cyc; end
        if (pulse0) begin n0_p++; last0_p = cyc; end
        if (es0) n0_s++;
        if (el0) n0_l++;
        check("excl", int'((int'(pulse) + int'(es) + int'(el)) <= 1), 1);
        check("excl0", int'((int'(pulse0) + int'(es0) + int'(el0)) <= 1), 1);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int w, input int gap);
        din = 1'b1;
        steps(w);
        din = 1'b0;
        steps(gap);
    endtask

    initial begin
        cyc = 0;
        clear();
        rst_n = 1'b0;
        din = 1'b0;
        din0 = 1'b0;
        steps(3);
        check("rst_busy", busy, 1);
        check("rst_width", width, 0);
        check("rst_pulse", pulse, 0);
        check("rst_errs", int'(es | el), 0);

        // 1: 20-cycle raw pulse from cycle 10
        rst_n = 1'b1;
        cyc = -1;
        clear();
        while (cyc < 10) step();
        din = 1'b1;
        steps(20);
        din = 1'b0;
        steps(2);
        check("t1_pulse_c32", pulse, 0);
        step();
        check("t1_pulse_c33", pulse, 1);
        check("t1_vld_c33", vld, 1);
        check("t1_width", width, 20);
        check("t1_busy_c33", busy, 1);
        step();
        check("t1_pulse_c34", pulse, 0);
        check("t1_busy_c34", busy, 0);
        check("t1_npulse", n_p, 1);
        check("t1_errs", n_s + n_l, 0);

        // 2: boundary widths and a short pulse
        clear();
        send(4, 10);
        check("t2_w4", width, 4);
        send(40, 10);
        check("t2_w40", width, 40);
        check("t2_np", n_p, 2);
        send(3, 10);
        check("t2_short", n_s, 1);
        check("t2_w_keep", width, 40);
        check("t2_np2", n_p, 2);

        // 3: width 41 then line held high
        clear();
        din = 1'b1;
        r = cyc;
        steps(100);
        check("t3_long", n_l, 1);
        check("t3_long_cyc", last_l, r + 43);
        check("t3_others", n_p + n_s, 0);
        check("t3_busy_high", busy, 1);
        din = 1'b0;
        steps(3);
        check("t3_busy_1low", busy, 1);
        step();
        check("t3_busy_2low", busy, 0);
        check("t3_w_keep", width, 40);

        // 4: back-to-back with one low, then with two lows
        steps(5);
        clear();
        din = 1'b1;
        steps(20);
        din = 1'b0;
        steps(1);
        din = 1'b1;
        steps(15);
        din = 1'b0;
        steps(10);
        check("t4a_np", n_p, 1);
        check("t4a_width", width, 20);
        check("t4a_errs", n_s + n_l, 0);
        clear();
        din = 1'b1;
        steps(20);
        din = 1'b0;
        steps(2);
        din = 1'b1;
        steps(15);
        din = 1'b0;
        steps(10);
        check("t4b_np", n_p, 2);
        check("t4b_width", width, 15);

        // 5: line high through reset
        din = 1'b1;
        rst_n = 1'b0;
        steps(3);
        check("t5_rst_width", width, 0);
        check("t5_rst_busy", busy, 1);
        rst_n = 1'b1;
        clear();
        steps(30);
        check("t5_quiet", n_p + n_s + n_l, 0);
        check("t5_busy", busy, 1);
        din = 1'b0;
        steps(5);
        send(10, 10);
        check("t5_np", n_p, 1);
        check("t5_width", width, 10);

        // 6: reset in the middle of a pulse, both variants
        clear();
        din = 1'b1;
        din0 = 1'b1;
        steps(8);
        rst_n = 1'b0;
        step();
        check("t6_width", width, 0);
        check("t6_busy", busy, 1);
        check("t6_strobes", int'(pulse | vld | es | el), 0);
        check("t6_width0", width0, 0);
        check("t6_busy0", busy0, 1);
        check("t6_strobes0", int'(pulse0 | vld0 | es0 | el0), 0);
        step();
        rst_n = 1'b1;
        steps(10);
        din = 1'b0;
        din0 = 1'b0;
        steps(10);
        check("t6_quiet", n_p + n_s + n_l, 0);
        check("t6_quiet0", n0_p + n0_s + n0_l, 0);
        din0 = 1'b1;
        steps(20);
        f = cyc;
        din0 = 1'b0;
        steps(3);
        check("t6_np0", n0_p, 1);
        check("t6_lat0", last0_p, f + 1);
        check("t6_width0_20", width0, 20);
        check("t6_busy0_idle", busy0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
